nfu1_tile_sched: RTL and testbench
==================================

# nfu1_tile_sched

Sequencing controller for the NFU-1 multiplier array. For one output block it walks the Ni/Tn input tiles: it issues paired reads to the input-neuron buffer (NBin) and the synapse buffer (SB), and presents each returned Tn-input / Tn×Tn-synapse tile to NFU-1 as a valid/ready beat tagged first/last for the NFU-2 adder tree. It sits between the on-chip buffers and the NFU-1 → NFU-2 pipeline. It carries no operand data; it carries only addresses, enables and sideband.

## Interface
- BIT_WIDTH, 16, operand width (informational; not used in control logic)
- Tn, 16, tile dimension (informational)
- ADDR_WIDTH, 10, NBin/SB entry address width
- CNT_WIDTH, 8, tile-count width
- STALL_WIDTH, 16, stall-counter width

- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- i_start  in  1  start pulse; sampled only in IDLE
- i_num_tiles  in  CNT_WIDTH  tiles in this block; sampled with i_start
- i_nbin_base  in  ADDR_WIDTH  first NBin entry; sampled with i_start
- i_sb_base  in  ADDR_WIDTH  first SB entry; sampled with i_start
- o_busy  out  1  high in RUN or DRAIN
- o_done  out  1  one-cycle completion pulse
- o_nbin_rd_en  out  1  NBin read strobe
- o_nbin_addr  out  ADDR_WIDTH  NBin read address
- o_sb_rd_en  out  1  SB read strobe; always equal to o_nbin_rd_en
- o_sb_addr  out  ADDR_WIDTH  SB read address
- o_nfu_valid  out  1  NFU-1 operands (buffer read data) are valid
- o_nfu_first  out  1  current beat is tile 0; NFU-2 clears its accumulator
- o_nfu_last  out  1  current beat is the final tile
- i_nfu_ready  in  1  NFU-2 accepts the beat
- o_stall_cycles  out  STALL_WIDTH  count of cycles with valid && !ready

## Operation
- Buffer contract: read data appears on the buffer outputs 1 cycle after rd_en and holds until the next rd_en.
- FSM states: IDLE, RUN, DRAIN. Encoding is free.
- IDLE
  - i_start with i_num_tiles == 0: no reads are issued. o_done pulses the next cycle. State stays IDLE.
  - i_start with i_num_tiles > 0: latch the count and both bases, clear the tile index and o_stall_cycles, then go to RUN.
  - i_start is ignored outside IDLE.
- Slot free is defined as: !o_nfu_valid || i_nfu_ready.
- RUN
  - Each cycle the slot is free, assert both rd_en strobes with o_nbin_addr = nbin_base + idx and o_sb_addr = sb_base + idx, then increment idx.
  - Addresses wrap modulo 2^ADDR_WIDTH.
  - After the read with idx == num_tiles−1, go to DRAIN.
  - No read is issued while the slot is not free.
- Output register update, every cycle:
  - o_nfu_valid ← rd_en || (o_nfu_valid && !i_nfu_ready).
  - first/last are loaded with the flags of the issuing read: first = (idx == 0), last = (idx == num_tiles−1). They hold while stalled.
  - When a single-tile block is issued, first and last are both high.
- DRAIN: when o_nfu_valid && o_nfu_last && i_nfu_ready, go to IDLE and pulse o_done in the following cycle.
- o_stall_cycles increments each cycle o_nfu_valid && !i_nfu_ready and saturates at all-ones. It holds its value after done until the next accepted start.
- Reset, including mid-operation: state goes to IDLE and all outputs go to 0.
  - The in-flight beat is dropped. No o_done is produced.
  - Downstream must be reset alongside.

## Timing
- Reset values: o_busy, o_done, both rd_en strobes, o_nfu_valid, o_nfu_first and o_nfu_last are 0. Both addresses are 0. o_stall_cycles is 0.
- rd_en and the addresses are combinational from the state, idx and slot-free signal. All other outputs are registered.
- i_start accepted at cycle 0 → o_busy = 1 and first rd_en at cycle 1 → first o_nfu_valid at cycle 2.
- With ready held high, N tiles produce valid beats in cycles 2..N+1 at one beat per cycle, with no bubbles. o_done pulses at cycle N+2. IDLE is reached at cycle N+2, so the next start can be accepted at cycle N+2.
- A ready deassertion stalls issue in the same cycle, so there is zero overrun. The held beat is re-presented unchanged.

## Test plan
- Basic run: num_tiles = 4, nbin_base = 0x010, sb_base = 0x200, ready = 1.
  - Required: reads at cycles 1–4 to 0x010–0x013 and 0x200–0x203.
  - Required: valid at cycles 2–5, first only at cycle 2, last only at cycle 5.
  - Required: done at cycle 6; o_stall_cycles = 0.
- Backpressure: num_tiles = 3, ready low in cycles 3–5.
  - Required: no rd_en in cycles 3–5, and beat 1 is held (same addresses already issued).
  - Required: all 3 beats are delivered exactly once; o_stall_cycles = 3.
- Single tile: num_tiles = 1 → one read, and one beat with first = last = 1.
- Zero tiles: num_tiles = 0 → no rd_en and no valid; o_done pulses at cycle 1.
- Wrap: nbin_base = 0x3FE, num_tiles = 4 → o_nbin_addr sequence 0x3FE, 0x3FF, 0x000, 0x001.
- Reset mid-run: assert rst while idx = 2 of 8.
  - Required: all outputs are 0 immediately, no o_done, and state is IDLE.
  - Required: a new start then runs normally. Also check that i_start pulsed during RUN is ignored.

Source files
------------

// File: rtl/nfu1_tile_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | nfu1_tile_sched                                                          |
// | Walks the input tiles of one output block: paired NBin/SB reads and     |
// | first/last-tagged valid/ready beats toward NFU-1 / NFU-2.                |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module nfu1_tile_sched #(
  parameter int BIT_WIDTH   = 16,
  parameter int Tn          = 16,
  parameter int ADDR_WIDTH  = 10,
  parameter int CNT_WIDTH   = 8,
  parameter int STALL_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_start,
  input  logic [CNT_WIDTH-1:0]   i_num_tiles,
  input  logic [ADDR_WIDTH-1:0]  i_nbin_base,
  input  logic [ADDR_WIDTH-1:0]  i_sb_base,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_nbin_rd_en,
  output logic [ADDR_WIDTH-1:0]  o_nbin_addr,
  output logic                   o_sb_rd_en,
  output logic [ADDR_WIDTH-1:0]  o_sb_addr,
  output logic                   o_nfu_valid,
  output logic                   o_nfu_first,
  output logic                   o_nfu_last,
  input  logic                   i_nfu_ready,
  output logic [STALL_WIDTH-1:0] o_stall_cycles
);

  // Operand width and tile size only describe the datapath this block steers.
  if (BIT_WIDTH < 1 || Tn < 1 || CNT_WIDTH < 1 || ADDR_WIDTH < 1 || STALL_WIDTH < 1) begin : g_badParam
    $error("nfu1_tile_sched: invalid parameter value");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t                r_state;
  logic [CNT_WIDTH-1:0]  r_numTiles;
  logic [CNT_WIDTH-1:0]  r_idx;
  logic [ADDR_WIDTH-1:0] r_nbinBase;
  logic [ADDR_WIDTH-1:0] r_sbBase;

  logic w_slotFree;
  logic w_rdEn;
  logic w_isLast;

  assign w_slotFree = !o_nfu_valid || i_nfu_ready;
  assign w_rdEn     = (r_state == S_RUN) && w_slotFree;
  assign w_isLast   = (r_idx == r_numTiles - CNT_WIDTH'(1));

  assign o_nbin_rd_en = w_rdEn;
  assign o_sb_rd_en   = w_rdEn;
  // Sum truncates to ADDR_WIDTH, so addresses wrap around the buffer.
  assign o_nbin_addr  = w_rdEn ? r_nbinBase + ADDR_WIDTH'(r_idx) : '0;
  assign o_sb_addr    = w_rdEn ? r_sbBase   + ADDR_WIDTH'(r_idx) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_numTiles     <= '0;
      r_idx          <= '0;
      r_nbinBase     <= '0;
      r_sbBase       <= '0;
      o_busy         <= 1'b0;
      o_done         <= 1'b0;
      o_nfu_valid    <= 1'b0;
      o_nfu_first    <= 1'b0;
      o_nfu_last     <= 1'b0;
      o_stall_cycles <= '0;
    end else begin
      o_done      <= 1'b0;
      o_nfu_valid <= w_rdEn || (o_nfu_valid && !i_nfu_ready);
      if (w_rdEn) begin
        o_nfu_first <= (r_idx == '0);
        o_nfu_last  <= w_isLast;
      end
      if (o_nfu_valid && !i_nfu_ready && !(&o_stall_cycles)) begin
        o_stall_cycles <= o_stall_cycles + STALL_WIDTH'(1);
      end

      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            if (i_num_tiles == '0) begin
              o_done <= 1'b1;
            end else begin
              r_numTiles     <= i_num_tiles;
              r_nbinBase     <= i_nbin_base;
              r_sbBase       <= i_sb_base;
              r_idx          <= '0;
              o_stall_cycles <= '0;
              o_busy         <= 1'b1;
              r_state        <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (w_rdEn) begin
            r_idx <= r_idx + CNT_WIDTH'(1);
            if (w_isLast) begin
              r_state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (o_nfu_valid && o_nfu_last && i_nfu_ready) begin
            o_busy  <= 1'b0;
            o_done  <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: begin
          o_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_nfu1_tile_sched.sv
`default_nettype none
// Bench for nfu1_tile_sched: expected reads/beats/done are queued when a block
// is started and compared against what the DUT and a buffer model produce.
module tb_nfu1_tile_sched;

  localparam int AW = 10;
  localparam int CW = 8;
  localparam int SW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_start;
  logic [CW-1:0] i_num_tiles;
  logic [AW-1:0] i_nbin_base;
  logic [AW-1:0] i_sb_base;
  logic          o_busy, o_done;
  logic          o_nbin_rd_en, o_sb_rd_en;
  logic [AW-1:0] o_nbin_addr, o_sb_addr;
  logic          o_nfu_valid, o_nfu_first, o_nfu_last;
  logic          i_nfu_ready;
  logic [SW-1:0] o_stall_cycles;

  nfu1_tile_sched #(
    .BIT_WIDTH(16), .Tn(16), .ADDR_WIDTH(AW), .CNT_WIDTH(CW), .STALL_WIDTH(SW)
  ) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_num_tiles(i_num_tiles),
    .i_nbin_base(i_nbin_base), .i_sb_base(i_sb_base), .o_busy(o_busy),
    .o_done(o_done), .o_nbin_rd_en(o_nbin_rd_en), .o_nbin_addr(o_nbin_addr),
    .o_sb_rd_en(o_sb_rd_en), .o_sb_addr(o_sb_addr), .o_nfu_valid(o_nfu_valid),
    .o_nfu_first(o_nfu_first), .o_nfu_last(o_nfu_last),
    .i_nfu_ready(i_nfu_ready), .o_stall_cycles(o_stall_cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            cyc;
    logic [AW-1:0] n;
    logic [AW-1:0] s;
    logic          f;
    logic          l;
  } ev_t;

  int  cyc = 0;
  int  enMis = 0;
  ev_t obsRd[$];
  ev_t obsBeat[$];
  int  obsDone[$];
  ev_t expRd[$];
  ev_t expBeat[$];
  logic [AW-1:0] bufN = '0;
  logic [AW-1:0] bufS = '0;

  int nCmp = 0;
  int nErr = 0;
  int t0;
  int cfgStallLo, cfgStallHi, cfgPulseAt;

  always @(posedge clk) cyc <= cyc + 1;

  // Buffer model: read data shows up one cycle after rd_en and holds.
  always @(posedge clk) begin
    if (o_nbin_rd_en) begin
      bufN <= o_nbin_addr;
      bufS <= o_sb_addr;
    end
  end

  always @(negedge clk) begin
    if (o_nbin_rd_en !== o_sb_rd_en) enMis++;
    if (o_nbin_rd_en) obsRd.push_back('{cyc, o_nbin_addr, o_sb_addr, 1'b0, 1'b0});
    if (o_nfu_valid && i_nfu_ready)
      obsBeat.push_back('{cyc, bufN, bufS, o_nfu_first, o_nfu_last});
    if (o_done) obsDone.push_back(cyc);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    nCmp++;
    assert (obs === expv) else begin
      nErr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chkAllZero(input string tag);
    chk({tag, "_busy"},  o_busy, 0);
    chk({tag, "_done"},  o_done, 0);
    chk({tag, "_rdN"},   o_nbin_rd_en, 0);
    chk({tag, "_rdS"},   o_sb_rd_en, 0);
    chk({tag, "_addrN"}, o_nbin_addr, 0);
    chk({tag, "_addrS"}, o_sb_addr, 0);
    chk({tag, "_valid"}, o_nfu_valid, 0);
    chk({tag, "_first"}, o_nfu_first, 0);
    chk({tag, "_last"},  o_nfu_last, 0);
    chk({tag, "_stall"}, o_stall_cycles, 0);
  endtask

  // Start a block, run a bounded number of cycles, then score the queues.
  task automatic runBlock(input string tag, input int n, input logic [AW-1:0] nb,
                          input logic [AW-1:0] sb, input int expDone, input int expStall);
    logic [AW-1:0] en, es;
    bit noStall;
    noStall = (cfgStallLo < 0);
    obsRd.delete(); obsBeat.delete(); obsDone.delete();
    expRd.delete(); expBeat.delete();
    for (int k = 0; k < n; k++) begin
      en = nb + AW'(k);
      es = sb + AW'(k);
      expRd.push_back('{1 + k, en, es, 1'b0, 1'b0});
      expBeat.push_back('{2 + k, en, es, (k == 0), (k == n - 1)});
    end
    i_num_tiles = CW'(n);
    i_nbin_base = nb;
    i_sb_base   = sb;
    i_start     = 1'b1;
    i_nfu_ready = 1'b1;
    t0 = cyc;
    for (int rel = 1; rel <= n + 12; rel++) begin
      tick();
      i_start     = (rel == cfgPulseAt);
      i_num_tiles = (rel == cfgPulseAt) ? '0 : CW'(n);
      i_nfu_ready = !(rel >= cfgStallLo && rel <= cfgStallHi);
      if (rel == 1 && n > 0) chk({tag, "_busyC1"}, o_busy, 1);
    end
    i_start = 1'b0;
    i_nfu_ready = 1'b1;

    chk({tag, "_nReads"}, obsRd.size(), n);
    for (int k = 0; k < n && k < obsRd.size(); k++) begin
      chk({tag, "_rdN"}, obsRd[k].n, expRd[k].n);
      chk({tag, "_rdS"}, obsRd[k].s, expRd[k].s);
      if (noStall) chk({tag, "_rdCyc"}, obsRd[k].cyc - t0, expRd[k].cyc);
      else chk({tag, "_noRdInStall"},
               ((obsRd[k].cyc - t0) >= cfgStallLo && (obsRd[k].cyc - t0) <= cfgStallHi), 0);
    end
    chk({tag, "_nBeats"}, obsBeat.size(), n);
    for (int k = 0; k < n && k < obsBeat.size(); k++) begin
      chk({tag, "_beatN"}, obsBeat[k].n, expBeat[k].n);
      chk({tag, "_beatS"}, obsBeat[k].s, expBeat[k].s);
      chk({tag, "_first"}, obsBeat[k].f, expBeat[k].f);
      chk({tag, "_last"},  obsBeat[k].l, expBeat[k].l);
      if (noStall) chk({tag, "_beatCyc"}, obsBeat[k].cyc - t0, expBeat[k].cyc);
    end
    chk({tag, "_nDone"}, obsDone.size(), 1);
    if (obsDone.size() > 0) chk({tag, "_doneCyc"}, obsDone[0] - t0, expDone);
    chk({tag, "_stallCnt"}, o_stall_cycles, expStall);
    chk({tag, "_busyEnd"}, o_busy, 0);
  endtask

  initial begin
    rst = 1'b1;
    i_start = 1'b0;
    i_num_tiles = '0;
    i_nbin_base = '0;
    i_sb_base = '0;
    i_nfu_ready = 1'b1;
    cfgStallLo = -1; cfgStallHi = -1; cfgPulseAt = -1;
    tick(); tick();
    chkAllZero("reset");
    rst = 1'b0;
    tick();

    // Basic: 4 tiles, no backpressure; done at cycle 6.
    runBlock("basic", 4, 10'h010, 10'h200, 6, 0);

    // Zero tiles: no traffic, done one cycle after start.
    runBlock("zero", 0, 10'h055, 10'h0AA, 1, 0);

    // Backpressure: ready low in cycles 3..5 holds beat 1; done at 3+2+3.
    cfgStallLo = 3; cfgStallHi = 5;
    runBlock("bp", 3, 10'h020, 10'h300, 8, 3);
    if (obsBeat.size() > 1) chk("bp_beat1Cyc", obsBeat[1].cyc - t0, 6);
    cfgStallLo = -1; cfgStallHi = -1;

    runBlock("single", 1, 10'h123, 10'h321, 3, 0);

    runBlock("wrap", 4, 10'h3FE, 10'h001, 6, 0);

    // Reset during the run, at the point where idx == 2 of 8.
    obsDone.delete(); obsRd.delete();
    i_num_tiles = 8'd8;
    i_nbin_base = 10'h100;
    i_sb_base   = 10'h180;
    i_start     = 1'b1;
    tick();
    i_start = 1'b0;
    tick(); tick();
    rst = 1'b1;
    #1;
    chkAllZero("midRst");
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    chk("midRst_nDone", obsDone.size(), 0);
    chk("midRst_nReads", obsRd.size(), 2);
    chk("midRst_busyAfter", o_busy, 0);

    // Fresh run after reset, with a zero-tile start pulsed mid-run that must be ignored.
    cfgPulseAt = 2;
    runBlock("postRst", 5, 10'h040, 10'h140, 7, 0);
    cfgPulseAt = -1;

    chk("rdEnPair", enMis, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
`default_nettype wire
